// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle control sequencer: state codes,
// opcodes and datapath mux selects.
package rv_ctrl_pkg;

   typedef enum logic [3:0] {
      ST_IDLE     = 4'd0,
      ST_FETCH    = 4'd1,
      ST_DECODE   = 4'd2,
      ST_MEM_ADDR = 4'd3,
      ST_MEM_RD   = 4'd4,
      ST_MEM_WB   = 4'd5,
      ST_MEM_WR   = 4'd6,
      ST_EXEC_R   = 4'd7,
      ST_EXEC_I   = 4'd8,
      ST_ALU_WB   = 4'd9,
      ST_BRANCH   = 4'd10,
      ST_JAL      = 4'd11,
      ST_ILLEGAL  = 4'd12
   } state_t;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;
   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;

   localparam logic [1:0] ALU_OP_ADD   = 2'b00;
   localparam logic [1:0] ALU_OP_SUB   = 2'b01;
   localparam logic [1:0] ALU_OP_RFUNC = 2'b10;
   localparam logic [1:0] ALU_OP_IFUNC = 2'b11;

   localparam logic [1:0] SRCA_PC    = 2'd0;
   localparam logic [1:0] SRCA_OLDPC = 2'd1;
   localparam logic [1:0] SRCA_REG   = 2'd2;

   localparam logic [1:0] SRCB_REG  = 2'd0;
   localparam logic [1:0] SRCB_FOUR = 2'd1;
   localparam logic [1:0] SRCB_IMM  = 2'd2;

   localparam logic [1:0] M2R_ALUOUT = 2'd0;
   localparam logic [1:0] M2R_MDR    = 2'd1;
   localparam logic [1:0] M2R_PC     = 2'd2;

   localparam logic PCSRC_ALU    = 1'b0;
   localparam logic PCSRC_ALUOUT = 1'b1;

   // An instruction retires on the edge that leaves one of these states;
   // a store only leaves MEM_WR once memory acknowledges it.
   function automatic logic retires(input state_t s, input logic mem_ready);
      case (s)
         ST_MEM_WB, ST_ALU_WB, ST_BRANCH, ST_JAL: return 1'b1;
         ST_MEM_WR:                               return mem_ready;
         default:                                 return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational state -> datapath control decode. Only the FETCH enables
// (mem_ready) and the BRANCH pc_write (zero/funct3) depend on inputs.
module mc_ctrl_decode
   import rv_ctrl_pkg::*;
(
   input  state_t     state,
   input  logic       mem_ready,
   input  logic       zero,
   input  logic [2:0] funct3,
   output logic       pc_write,
   output logic       ir_write,
   output logic       mem_read,
   output logic       mem_write,
   output logic       reg_write,
   output logic       iord,
   output logic [1:0] mem_to_reg,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic       pc_source,
   output logic       illegal_instr
);

   // Per-state control outputs; everything defaults low.
   always_comb begin
      pc_write      = 1'b0;
      ir_write      = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      reg_write     = 1'b0;
      iord          = 1'b0;
      mem_to_reg    = M2R_ALUOUT;
      alu_src_a     = SRCA_PC;
      alu_src_b     = SRCB_REG;
      alu_op        = ALU_OP_ADD;
      pc_source     = PCSRC_ALU;
      illegal_instr = 1'b0;
      case (state)
         ST_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = SRCB_FOUR;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
         end
         ST_DECODE: begin
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_IMM;
         end
         ST_MEM_ADDR: begin
            alu_src_a = SRCA_REG;
            alu_src_b = SRCB_IMM;
         end
         ST_MEM_RD: begin
            mem_read = 1'b1;
            iord     = 1'b1;
         end
         ST_MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = M2R_MDR;
         end
         ST_MEM_WR: begin
            mem_write = 1'b1;
            iord      = 1'b1;
         end
         ST_EXEC_R: begin
            alu_src_a = SRCA_REG;
            alu_src_b = SRCB_REG;
            alu_op    = ALU_OP_RFUNC;
         end
         ST_EXEC_I: begin
            alu_src_a = SRCA_REG;
            alu_src_b = SRCB_IMM;
            alu_op    = ALU_OP_IFUNC;
         end
         ST_ALU_WB: begin
            reg_write = 1'b1;
         end
         ST_BRANCH: begin
            alu_src_a = SRCA_REG;
            alu_src_b = SRCB_REG;
            alu_op    = ALU_OP_SUB;
            pc_source = PCSRC_ALUOUT;
            pc_write  = ((funct3 == F3_BEQ) &  zero) |
                        ((funct3 == F3_BNE) & ~zero);
         end
         ST_JAL: begin
            reg_write  = 1'b1;
            mem_to_reg = M2R_PC;
            pc_write   = 1'b1;
            pc_source  = PCSRC_ALUOUT;
         end
         ST_ILLEGAL: begin
            illegal_instr = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RISC-V control sequencer: state register, next-state logic
// and retired-instruction counter. Control outputs come from mc_ctrl_decode.
//
//   state     | meaning
//   ----------+--------------------------------------------------
//   IDLE      | post-reset bubble, all outputs low
//   FETCH     | read IR at PC, PC+4 (waits on mem_ready)
//   DECODE    | classify opcode, branch/jump target into ALUOut
//   MEM_ADDR  | effective address regA + imm
//   MEM_RD    | load data read (waits on mem_ready)
//   MEM_WB    | MDR -> register file
//   MEM_WR    | store data write (waits on mem_ready)
//   EXEC_R    | ALU regA op regB
//   EXEC_I    | ALU regA op imm
//   ALU_WB    | ALUOut -> register file
//   BRANCH    | compare, conditional PC <- ALUOut
//   JAL       | rd <- PC, PC <- ALUOut
//   ILLEGAL   | flag undecodable instruction, no side effects
module multicycle_control_fsm
   import rv_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [6:0]  opcode,
   input  logic [2:0]  funct3,
   input  logic [6:0]  funct7,
   input  logic        zero,
   input  logic        mem_ready,
   output logic        pc_write,
   output logic        ir_write,
   output logic        mem_read,
   output logic        mem_write,
   output logic        reg_write,
   output logic        iord,
   output logic [1:0]  mem_to_reg,
   output logic [1:0]  alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [1:0]  alu_op,
   output logic        pc_source,
   output logic        illegal_instr,
   output logic [3:0]  state,
   output logic [31:0] instret
);

   state_t      state_q;
   state_t      state_d;
   logic [31:0] instret_q;

   // State register; reset forces IDLE so all decoded outputs drop at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic; IR fields are stable from DECODE until the next FETCH.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  state_d = ST_FETCH;
         ST_FETCH: if (mem_ready) state_d = ST_DECODE;
         ST_DECODE: begin
            case (opcode)
               OP_R:      state_d = (funct7 == F7_BASE || funct7 == F7_ALT) ?
                                    ST_EXEC_R : ST_ILLEGAL;
               OP_I:      state_d = ST_EXEC_I;
               OP_LOAD,
               OP_STORE:  state_d = ST_MEM_ADDR;
               OP_BRANCH: state_d = (funct3 == F3_BEQ || funct3 == F3_BNE) ?
                                    ST_BRANCH : ST_ILLEGAL;
               OP_JAL:    state_d = ST_JAL;
               default:   state_d = ST_ILLEGAL;
            endcase
         end
         ST_MEM_ADDR: state_d = (opcode == OP_LOAD) ? ST_MEM_RD : ST_MEM_WR;
         ST_MEM_RD:   if (mem_ready) state_d = ST_MEM_WB;
         ST_MEM_WR:   if (mem_ready) state_d = ST_FETCH;
         ST_EXEC_R,
         ST_EXEC_I:   state_d = ST_ALU_WB;
         ST_MEM_WB,
         ST_ALU_WB,
         ST_BRANCH,
         ST_JAL,
         ST_ILLEGAL:  state_d = ST_FETCH;
         default:     state_d = ST_IDLE;
      endcase
   end

   // Retired-instruction counter, free-running wrap at 2^32.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                          instret_q <= 32'd0;
      else if (retires(state_q, mem_ready)) instret_q <= instret_q + 32'd1;
   end

   assign state   = state_q;
   assign instret = instret_q;

   mc_ctrl_decode u_decode (
      .state         (state_q),
      .mem_ready     (mem_ready),
      .zero          (zero),
      .funct3        (funct3),
      .pc_write      (pc_write),
      .ir_write      (ir_write),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .reg_write     (reg_write),
      .iord          (iord),
      .mem_to_reg    (mem_to_reg),
      .alu_src_a     (alu_src_a),
      .alu_src_b     (alu_src_b),
      .alu_op        (alu_op),
      .pc_source     (pc_source),
      .illegal_instr (illegal_instr)
   );

endmodule
